// File: rtl/shared_bank_allocator_pkg.sv
// Shared definitions for the per-bank ownership controller: FSM state codes
// and the ceiling-log2 helper used to size counters and pointers.
package shared_bank_allocator_pkg;

    // Two-bit state code; the fourth code is unused and recovers to ENABLE.
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_ENABLE = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_SWITCH = 2'b10;

    // Bits needed to hold values 0 .. value-1, never less than one bit.
    function automatic int clogb(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/shared_bank_allocator_rr_max_select.sv
// Picks the congested port with the largest window count. Ports are visited
// starting just after the round-robin pointer, so among equal counts the
// first one met in that order wins.
module rr_max_select
    import shared_bank_allocator_pkg::*;
#(
    parameter int num_ports     = 5,
    parameter int counter_width = 5,
    parameter int ptr_width     = 3
) (
    input  logic [num_ports-1:0][counter_width-1:0] counters,
    input  logic [num_ports-1:0]                    congested,
    input  logic [ptr_width-1:0]                    rr_ptr,
    output logic                                    valid,
    output logic [ptr_width-1:0]                    index
);

    int                       port;
    logic [counter_width-1:0] best;

    // Rotating scan; only a strictly larger count displaces the current pick
    always_comb begin
        valid = 1'b0;
        index = '0;
        best  = '0;
        port  = 0;
        for (int k = 1; k <= num_ports; k++) begin
            port = int'(rr_ptr) + k;
            if (port >= num_ports) begin
                port = port - num_ports;
            end
            if (congested[port] && (!valid || (counters[port] > best))) begin
                valid = 1'b1;
                index = ptr_width'(port);
                best  = counters[port];
            end
        end
    end

endmodule

// File: rtl/shared_bank_allocator.sv
// Dynamic ownership controller for one shared input-VC memory bank.
// Samples per-port congestion over a fixed window, picks the most congested
// port, drains the bank (optionally bounded by a timeout) and then hands the
// one-hot bank grant to that port.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_ENABLE | owner stable, VC allocation allowed, congestion window running
// ST_DRAIN  | allocation blocked, waiting for the bank to empty or time out
// ST_SWITCH | bank empty, grant moves to the target port on the next edge
//
// Grant vector ordering: port 0 is the MSB, port num_ports-1 the LSB.
module shared_bank_allocator
    import shared_bank_allocator_pkg::*;
#(
    parameter int num_ports = 5,
    parameter int num_vcs   = 10,
    parameter int num_banks = 5,
    parameter int bank_id   = 0,
    parameter int threshold = 4,
    parameter int window    = 16,
    parameter int max_drain = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [num_ports*num_vcs-1:0]         allocated_ip_shared_ivc,
    input  logic [num_vcs/num_banks-1:0]         shared_ivc_empty,
    output logic [num_ports-1:0]                 memory_bank_grant_out,
    output logic                                 ready_for_allocation,
    output logic                                 realloc_pulse,
    output logic                                 drain_abort
);

    localparam int num_vcs_per_bank = num_vcs / num_banks;
    localparam int counter_width    = clogb(window + 1);
    localparam int ptr_width        = clogb(num_ports);
    localparam int drain_width      = clogb(max_drain + 1);
    localparam int slice_base       = bank_id * num_vcs_per_bank;

    localparam logic [counter_width-1:0] WIN_LAST   = counter_width'(window - 1);
    localparam logic [counter_width-1:0] WIN_MAX    = counter_width'(window);
    localparam logic [counter_width-1:0] THRESH     = counter_width'(threshold);
    localparam logic [drain_width-1:0]   DRAIN_LAST = drain_width'(max_drain - 1);
    localparam logic [ptr_width-1:0]     RESET_PTR  = ptr_width'(bank_id % num_ports);

    // One-hot grant for a port index, port 0 in the MSB position.
    function automatic logic [num_ports-1:0] port_grant(input logic [ptr_width-1:0] idx);
        logic [num_ports-1:0] g;
        for (int p = 0; p < num_ports; p++) begin
            g[num_ports-1-p] = (idx == ptr_width'(p));
        end
        return g;
    endfunction

    localparam logic [num_ports-1:0] RESET_GRANT = port_grant(RESET_PTR);

    logic [1:0]                              state_q, state_d;
    logic [num_ports-1:0][counter_width-1:0] counter_q, counter_d;
    logic [counter_width-1:0]                win_timer_q, win_timer_d;
    logic [drain_width-1:0]                  drain_timer_q, drain_timer_d;
    logic [num_ports-1:0]                    grant_q, grant_d;
    logic [ptr_width-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [ptr_width-1:0]                    target_q, target_d;
    logic                                    ready_q, ready_d;
    logic                                    realloc_pulse_q, realloc_pulse_d;
    logic                                    drain_abort_q, drain_abort_d;

    logic [num_ports-1:0] port_full;
    logic [num_ports-1:0] port_busy;
    logic [num_ports-1:0] congested;
    logic                 bank_busy;
    logic                 drain_done;
    logic                 sel_valid;
    logic [ptr_width-1:0] sel_idx;
    logic                 alloc_unused;

    // VC flags belonging to other banks have no bearing on this controller.
    assign alloc_unused = ^allocated_ip_shared_ivc;

    // Reduce each port's slice of this bank to full / busy flags
    always_comb begin
        port_full = '0;
        port_busy = '0;
        for (int p = 0; p < num_ports; p++) begin
            port_full[p] = &allocated_ip_shared_ivc[p*num_vcs + slice_base +: num_vcs_per_bank];
            port_busy[p] = |allocated_ip_shared_ivc[p*num_vcs + slice_base +: num_vcs_per_bank];
        end
    end

    assign bank_busy  = |port_busy;
    assign drain_done = !bank_busy && (&shared_ivc_empty);

    // Congestion flags come from the registered counts only
    always_comb begin
        congested = '0;
        for (int p = 0; p < num_ports; p++) begin
            congested[p] = (counter_q[p] >= THRESH);
        end
    end

    rr_max_select #(
        .num_ports     (num_ports),
        .counter_width (counter_width),
        .ptr_width     (ptr_width)
    ) u_select (
        .counters  (counter_q),
        .congested (congested),
        .rr_ptr    (rr_ptr_q),
        .valid     (sel_valid),
        .index     (sel_idx)
    );

    // Next-state logic: window sampling, drain supervision and grant handover
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        win_timer_d     = win_timer_q;
        drain_timer_d   = drain_timer_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        target_d        = target_q;
        ready_d         = ready_q;
        realloc_pulse_d = 1'b0;
        drain_abort_d   = 1'b0;

        case (state_q)
            ST_ENABLE: begin
                ready_d       = 1'b1;
                drain_timer_d = '0;
                if (win_timer_q == WIN_LAST) begin
                    // Last window cycle: decide on registered counts, drop this sample.
                    counter_d   = '0;
                    win_timer_d = '0;
                    if (sel_valid && ((grant_q & port_grant(sel_idx)) == '0)) begin
                        target_d = sel_idx;
                        state_d  = ST_DRAIN;
                        ready_d  = 1'b0;
                    end
                end else begin
                    win_timer_d = win_timer_q + 1'b1;
                    for (int p = 0; p < num_ports; p++) begin
                        if (port_full[p] && (counter_q[p] != WIN_MAX)) begin
                            counter_d[p] = counter_q[p] + 1'b1;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                counter_d     = '0;
                win_timer_d   = '0;
                ready_d       = 1'b0;
                drain_timer_d = drain_timer_q + 1'b1;
                if (drain_done) begin
                    state_d = ST_SWITCH;
                end else if ((max_drain != 0) && (drain_timer_q == DRAIN_LAST)) begin
                    drain_abort_d = 1'b1;
                    state_d       = ST_ENABLE;
                    ready_d       = 1'b1;
                    drain_timer_d = '0;
                end
            end

            ST_SWITCH: begin
                counter_d       = '0;
                win_timer_d     = '0;
                drain_timer_d   = '0;
                grant_d         = port_grant(target_q);
                rr_ptr_d        = target_q;
                realloc_pulse_d = 1'b1;
                ready_d         = 1'b1;
                state_d         = ST_ENABLE;
            end

            default: begin
                // Unused code: fall back to the power-on ownership.
                state_d       = ST_ENABLE;
                counter_d     = '0;
                win_timer_d   = '0;
                drain_timer_d = '0;
                grant_d       = RESET_GRANT;
                rr_ptr_d      = RESET_PTR;
                target_d      = RESET_PTR;
                ready_d       = 1'b1;
            end
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_ENABLE;
            counter_q       <= '0;
            win_timer_q     <= '0;
            drain_timer_q   <= '0;
            grant_q         <= RESET_GRANT;
            rr_ptr_q        <= RESET_PTR;
            target_q        <= RESET_PTR;
            ready_q         <= 1'b1;
            realloc_pulse_q <= 1'b0;
            drain_abort_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            win_timer_q     <= win_timer_d;
            drain_timer_q   <= drain_timer_d;
            grant_q         <= grant_d;
            rr_ptr_q        <= rr_ptr_d;
            target_q        <= target_d;
            ready_q         <= ready_d;
            realloc_pulse_q <= realloc_pulse_d;
            drain_abort_q   <= drain_abort_d;
        end
    end

    assign memory_bank_grant_out = grant_q;
    assign ready_for_allocation  = ready_q;
    assign realloc_pulse         = realloc_pulse_q;
    assign drain_abort           = drain_abort_q;

endmodule

// File: tb/tb_shared_bank_allocator.sv
// Randomised bench for shared_bank_allocator: a window-level reference model
// counts full cycles per port, picks the winner and predicts drain/switch or
// drain/abort timing, and every DUT output is compared against it.
module tb_shared_bank_allocator;

    localparam int NP   = 5;
    localparam int NV   = 10;
    localparam int NB   = 5;
    localparam int BANK = 2;
    localparam int THR  = 4;
    localparam int WIN  = 16;
    localparam int MAXD = 8;
    localparam int VPB  = NV / NB;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*NV-1:0]  alloc;
    logic [VPB-1:0]    empty;
    logic [NP-1:0]     grant;
    logic              ready;
    logic              realloc;
    logic              abort_p;

    int n_cmp = 0;
    int n_bad = 0;
    int m_owner;
    int m_rr;

    always #5 clk = ~clk;

    shared_bank_allocator #(
        .num_ports (NP),
        .num_vcs   (NV),
        .num_banks (NB),
        .bank_id   (BANK),
        .threshold (THR),
        .window    (WIN),
        .max_drain (MAXD)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .allocated_ip_shared_ivc (alloc),
        .shared_ivc_empty        (empty),
        .memory_bank_grant_out   (grant),
        .ready_for_allocation    (ready),
        .realloc_pulse           (realloc),
        .drain_abort             (abort_p)
    );

    function automatic logic [NP-1:0] grant_of(input int p);
        logic [NP-1:0] g;
        g = '0;
        g[NP-1-p] = 1'b1;
        return g;
    endfunction

    function automatic logic [NP*NV-1:0] noise();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NP*NV-1:0];
    endfunction

    // Most congested port, ties resolved by first hit scanning from rr+1.
    function automatic int model_pick(input int cnt[NP], input int rr);
        int best;
        int bestc;
        best  = -1;
        bestc = -1;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (rr + k) % NP;
            if (cnt[p] >= THR && cnt[p] > bestc) begin
                best  = p;
                bestc = cnt[p];
            end
        end
        return best;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ports(input logic [NP-1:0] full_m, input logic [NP-1:0] part_m);
        logic [NP*NV-1:0] v;
        v = noise();
        for (int p = 0; p < NP; p++) begin
            if (full_m[p])      v[p*NV + BANK*VPB +: VPB] = '1;
            else if (part_m[p]) v[p*NV + BANK*VPB +: VPB] = VPB'(1);
            else                v[p*NV + BANK*VPB +: VPB] = '0;
        end
        alloc = v;
        empty = VPB'($urandom);
    endtask

    task automatic drive_clean();
        logic [NP*NV-1:0] v;
        v = noise();
        for (int p = 0; p < NP; p++) v[p*NV + BANK*VPB +: VPB] = '0;
        alloc = v;
        empty = '1;
    endtask

    task automatic drive_busy();
        drive_clean();
        if ($urandom_range(0, 1) == 0) begin
            alloc[$urandom_range(0, NP-1)*NV + BANK*VPB + $urandom_range(0, VPB-1)] = 1'b1;
        end else begin
            empty = VPB'($urandom) & ~(VPB'(1) << $urandom_range(0, VPB-1));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_clean();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        m_owner = BANK % NP;
        m_rr    = BANK % NP;
    endtask

    // One full sampling window; returns the model's decision.
    task automatic run_window(input logic [NP-1:0] pat [WIN], input logic [NP-1:0] part [WIN],
                              output int cand, output bit moved);
        int cnt[NP];
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int c = 0; c < WIN; c++) begin
            drive_ports(pat[c], part[c]);
            if (c < WIN - 1) begin
                for (int p = 0; p < NP; p++) begin
                    if (pat[c][p] && cnt[p] < WIN) cnt[p]++;
                end
            end
            tick();
            if (c < WIN - 1) begin
                n_cmp++;
                if ({ready, realloc, abort_p} !== 3'b100) begin
                    n_bad++;
                    $display("FAIL window_idle c=%0d: ready/realloc/abort=%b expected 100", c, {ready, realloc, abort_p});
                end
            end
        end
        cand  = model_pick(cnt, m_rr);
        moved = (cand >= 0) && (cand != m_owner);
        n_cmp++;
        if (ready !== !moved) begin
            n_bad++;
            $display("FAIL window_decision: ready=%b expected %b (cand=%0d owner=%0d)", ready, !moved, cand, m_owner);
        end
        n_cmp++;
        if (grant !== grant_of(m_owner)) begin
            n_bad++;
            $display("FAIL window_grant: grant=%b expected %b", grant, grant_of(m_owner));
        end
    endtask

    // Bank stays busy for 'hold' DRAIN cycles, then goes clean.
    task automatic run_drain(input int hold, input int target);
        for (int k = 1; k <= MAXD; k++) begin
            if (k <= hold) drive_busy();
            else           drive_clean();
            tick();
            if (k > hold) begin
                n_cmp++;
                if ({ready, realloc, abort_p} !== 3'b000 || grant !== grant_of(m_owner)) begin
                    n_bad++;
                    $display("FAIL switch_cycle: ready/realloc/abort=%b grant=%b expected 000 %b",
                             {ready, realloc, abort_p}, grant, grant_of(m_owner));
                end
                drive_ports(NP'($urandom), NP'($urandom));
                tick();
                n_cmp++;
                if (grant !== grant_of(target) || {ready, realloc, abort_p} !== 3'b110) begin
                    n_bad++;
                    $display("FAIL handover: grant=%b ready/realloc/abort=%b expected %b 110",
                             grant, {ready, realloc, abort_p}, grant_of(target));
                end
                m_owner = target;
                m_rr    = target;
                return;
            end else if (k == MAXD) begin
                n_cmp++;
                if (grant !== grant_of(m_owner) || {ready, realloc, abort_p} !== 3'b101) begin
                    n_bad++;
                    $display("FAIL drain_abort: grant=%b ready/realloc/abort=%b expected %b 101",
                             grant, {ready, realloc, abort_p}, grant_of(m_owner));
                end
                return;
            end else begin
                n_cmp++;
                if ({ready, realloc, abort_p} !== 3'b000 || grant !== grant_of(m_owner)) begin
                    n_bad++;
                    $display("FAIL draining k=%0d: ready/realloc/abort=%b grant=%b expected 000 %b",
                             k, {ready, realloc, abort_p}, grant, grant_of(m_owner));
                end
            end
        end
    endtask

    task automatic window_and_drain(input logic [NP-1:0] pat [WIN], input int hold);
        logic [NP-1:0] part [WIN];
        int  cand;
        bit  moved;
        for (int c = 0; c < WIN; c++) part[c] = NP'($urandom) & ~pat[c];
        run_window(pat, part, cand, moved);
        if (moved) run_drain(hold, cand);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (grant !== 5'b00100) begin
            n_bad++;
            $display("FAIL reset_grant: grant=%b expected 00100", grant);
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: ready=%b expected 1", ready);
        end
        n_cmp++;
        if (realloc !== 1'b0 || abort_p !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pulses: realloc=%b abort=%b expected 0 0", realloc, abort_p);
        end
    endtask

    task automatic test_single_port();
        logic [NP-1:0] pat [WIN];
        do_reset();
        for (int c = 0; c < WIN; c++) pat[c] = grant_of(0) >> (NP-1);
        window_and_drain(pat, $urandom_range(1, 5));
        n_cmp++;
        if (grant !== 5'b10000) begin
            n_bad++;
            $display("FAIL single_port_grant: grant=%b expected 10000", grant);
        end
    endtask

    task automatic test_tie();
        logic [NP-1:0] pat [WIN];
        do_reset();
        for (int c = 0; c < WIN; c++) pat[c] = NP'((1 << 1) | (1 << 3));
        window_and_drain(pat, 1);
        n_cmp++;
        if (grant !== 5'b00010) begin
            n_bad++;
            $display("FAIL tie_first: grant=%b expected 00010", grant);
        end
        for (int c = 0; c < WIN; c++) pat[c] = NP'((1 << 3) | (1 << 4));
        window_and_drain(pat, 0);
        n_cmp++;
        if (grant !== 5'b00001) begin
            n_bad++;
            $display("FAIL tie_second: grant=%b expected 00001", grant);
        end
    endtask

    task automatic test_threshold();
        logic [NP-1:0] pat [WIN];
        do_reset();
        // Three counted cycles plus the dropped last-cycle sample: below threshold.
        for (int c = 0; c < WIN; c++) pat[c] = (c < 3 || c == WIN-1) ? NP'(1) : '0;
        window_and_drain(pat, 0);
        // Only the owner congested: nothing to do.
        for (int c = 0; c < WIN; c++) pat[c] = NP'(1 << 2);
        window_and_drain(pat, 0);
        // Exactly threshold counts on port 0: moves.
        for (int c = 0; c < WIN; c++) pat[c] = (c < THR) ? NP'(1) : '0;
        window_and_drain(pat, 2);
        n_cmp++;
        if (grant !== 5'b10000) begin
            n_bad++;
            $display("FAIL threshold_exact: grant=%b expected 10000", grant);
        end
    endtask

    task automatic test_abort();
        logic [NP-1:0] pat [WIN];
        do_reset();
        for (int c = 0; c < WIN; c++) pat[c] = NP'(1 << 4);
        window_and_drain(pat, MAXD + $urandom_range(0, 3));
        n_cmp++;
        if (grant !== 5'b00100) begin
            n_bad++;
            $display("FAIL abort_grant: grant=%b expected 00100", grant);
        end
        // Bank empties on the very cycle the timeout would fire: drain wins.
        window_and_drain(pat, MAXD - 1);
        n_cmp++;
        if (grant !== 5'b00001) begin
            n_bad++;
            $display("FAIL drain_beats_timeout: grant=%b expected 00001", grant);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] pat [WIN];
        int prob[NP];
        do_reset();
        for (int w = 0; w < 24; w++) begin
            for (int p = 0; p < NP; p++) prob[p] = $urandom_range(0, 100);
            for (int c = 0; c < WIN; c++) begin
                for (int p = 0; p < NP; p++) pat[c][p] = ($urandom_range(0, 99) < prob[p]);
            end
            window_and_drain(pat, $urandom_range(0, 10));
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [NP-1:0] pat [WIN];
        logic [NP-1:0] part [WIN];
        int  cand;
        bit  moved;
        do_reset();
        for (int c = 0; c < WIN; c++) begin
            pat[c]  = NP'(1);
            part[c] = '0;
        end
        run_window(pat, part, cand, moved);
        drive_busy();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 5'b00100 || {ready, realloc, abort_p} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_mid_drain: grant=%b ready/realloc/abort=%b expected 00100 100",
                     grant, {ready, realloc, abort_p});
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_owner = BANK % NP;
        m_rr    = BANK % NP;
        for (int c = 0; c < WIN; c++) pat[c] = (c < THR) ? NP'(1 << 1) : '0;
        window_and_drain(pat, 0);
        n_cmp++;
        if (grant !== 5'b01000) begin
            n_bad++;
            $display("FAIL after_reset_window: grant=%b expected 01000", grant);
        end
    endtask

    initial begin
        reset = 1'b1;
        alloc = '0;
        empty = '1;
        test_reset();
        test_single_port();
        test_tie();
        test_threshold();
        test_abort();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
